// File: rtl/fetch_unit.sv
// fetch_unit: program-counter sequencer for a simple in-order core.
//
// Holds the program at address 0 while start is high. The program begins on
// the first cycle start is sampled low. Each RUN cycle it steps the PC,
// redirects it to an absolute or relative branch target, or halts.
//
// Optional build macro:
//   FETCH_CYCLE_COUNT_EN - adds the 16-bit saturating cycle_count output.
//
// Ports:
//   clk            in   clock; all state updates on the rising edge
//   reset          in   synchronous, active-high reset
//   start          in   level; high holds/returns the program to address 0
//   halt           in   current instruction is the last one
//   branch_abs     in   current instruction is an absolute jump
//   branch_rel     in   current instruction is a relative branch
//   taken          in   branch condition true (qualifies both branch kinds)
//   target         in   [D]     absolute jump address
//   offset         in   [OFS_W] signed relative displacement
//   programCounter out  [D]     registered instruction-memory address
//   fetch_valid    out  programCounter addresses a live instruction
//   done           out  program has halted
//   cycle_count    out  [16]    RUN cycles since LOAD (FETCH_CYCLE_COUNT_EN only)
module fetch_unit #(
    parameter int D     = 12,
    parameter int OFS_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    halt,
    input  logic                    branch_abs,
    input  logic                    branch_rel,
    input  logic                    taken,
    input  logic [D-1:0]            target,
    input  logic signed [OFS_W-1:0] offset,
    output logic [D-1:0]            programCounter,
    output logic                    fetch_valid,
`ifdef FETCH_CYCLE_COUNT_EN
    output logic                    done,
    output logic [15:0]             cycle_count
`else
    output logic                    done
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [D-1:0]   pc_next;

    // Sequential increment; wraps modulo 2^D.
    function automatic logic [D-1:0] pc_inc(input logic [D-1:0] pc);
        return pc + 1'b1;
    endfunction

    // Relative branch: sign-extend the displacement to D bits, then add with
    // natural modulo-2^D wrap in both directions.
    function automatic logic [D-1:0] pc_add(input logic [D-1:0] pc,
                                            input logic signed [OFS_W-1:0] ofs);
        logic signed [D-1:0] ext;
        ext = D'(ofs);
        return pc + $unsigned(ext);
    endfunction

    always_comb begin
        state_next = state;
        pc_next    = programCounter;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    pc_next    = '0;
                end
            end
            LOAD: begin
                pc_next = '0;
                if (!start) state_next = RUN;
            end
            RUN: begin
                // start outranks everything, then halt, then absolute,
                // then relative; abs+rel together resolve to the absolute target.
                if (start) begin
                    state_next = LOAD;
                    pc_next    = '0;
                end else if (halt) begin
                    state_next = DONE;
                end else if (branch_abs && taken) begin
                    pc_next = target;
                end else if (branch_rel && taken) begin
                    pc_next = pc_add(programCounter, offset);
                end else begin
                    pc_next = pc_inc(programCounter);
                end
            end
            DONE: begin
                if (start) begin
                    state_next = LOAD;
                    pc_next    = '0;
                end
            end
            default: begin
                state_next = IDLE;
                pc_next    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            programCounter <= '0;
        end else begin
            state          <= state_next;
            programCounter <= pc_next;
        end
    end

    assign fetch_valid = (state == RUN);
    assign done        = (state == DONE);

`ifdef FETCH_CYCLE_COUNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Counts every RUN cycle including the halting one; holds elsewhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (state == LOAD) begin
            cycle_count <= '0;
        end else if (state == RUN) begin
            cycle_count <= sat_inc16(cycle_count);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    localparam int D     = 12;
    localparam int OFS_W = 8;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic                    halt;
    logic                    branch_abs;
    logic                    branch_rel;
    logic                    taken;
    logic [D-1:0]            target;
    logic signed [OFS_W-1:0] offset;
    logic [D-1:0]            programCounter;
    logic                    fetch_valid;
    logic                    done;
`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0]             cycle_count;
`endif

    int checks = 0;
    int errors = 0;

    fetch_unit #(.D(D), .OFS_W(OFS_W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .halt(halt),
        .branch_abs(branch_abs),
        .branch_rel(branch_rel),
        .taken(taken),
        .target(target),
        .offset(offset),
        .programCounter(programCounter),
        .fetch_valid(fetch_valid),
`ifdef FETCH_CYCLE_COUNT_EN
        .done(done),
        .cycle_count(cycle_count)
`else
        .done(done)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        halt = 1'b0; branch_abs = 1'b0; branch_rel = 1'b0; taken = 1'b0;
        target = '0; offset = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; clear_ctl();
        step();
        checks++; if (programCounter !== 12'h000) begin errors++; $display("FAIL reset_pc got=%h exp=000", programCounter); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", fetch_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        reset = 1'b0; start = 1'b0;
        step();
        checks++; if (fetch_valid !== 1'b0 || programCounter !== 12'h000) begin errors++; $display("FAIL idle_hold fv=%b pc=%h exp fv=0 pc=000", fetch_valid, programCounter); end
    endtask

    task automatic test_sequential();
        logic [D-1:0] exp_pc;
        start = 1'b1;
        step(); step();
        checks++; if (fetch_valid !== 1'b0 || programCounter !== 12'h000) begin errors++; $display("FAIL load_hold fv=%b pc=%h exp fv=0 pc=000", fetch_valid, programCounter); end
        start = 1'b0;
        step();
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL run_entry_fv got=%b exp=1", fetch_valid); end
        for (int i = 0; i < 4; i++) begin
            exp_pc = D'(i);
            checks++; if (programCounter !== exp_pc) begin errors++; $display("FAIL seq_pc%0d got=%h exp=%h", i, programCounter, exp_pc); end
            if (i < 3) step();
        end
    endtask

    task automatic test_branches();
        step(); step();
        checks++; if (programCounter !== 12'h005) begin errors++; $display("FAIL pc_at5 got=%h exp=005", programCounter); end
        branch_rel = 1'b1; taken = 1'b1; offset = 8'shFD;
        step();
        checks++; if (programCounter !== 12'h002) begin errors++; $display("FAIL rel_back got=%h exp=002", programCounter); end
        branch_rel = 1'b0; branch_abs = 1'b1; target = 12'h100;
        step();
        checks++; if (programCounter !== 12'h100) begin errors++; $display("FAIL abs_jump got=%h exp=100", programCounter); end
        taken = 1'b0;
        step();
        checks++; if (programCounter !== 12'h101) begin errors++; $display("FAIL abs_not_taken got=%h exp=101", programCounter); end
        branch_abs = 1'b0; branch_rel = 1'b1; offset = 8'sh40;
        step();
        checks++; if (programCounter !== 12'h102) begin errors++; $display("FAIL rel_not_taken got=%h exp=102", programCounter); end
        clear_ctl();
    endtask

    task automatic test_wrap();
        branch_abs = 1'b1; taken = 1'b1; target = 12'hFFF;
        step();
        clear_ctl();
        step();
        checks++; if (programCounter !== 12'h000) begin errors++; $display("FAIL inc_wrap got=%h exp=000", programCounter); end
        branch_rel = 1'b1; taken = 1'b1; offset = -8'sd1;
        step();
        checks++; if (programCounter !== 12'hFFF) begin errors++; $display("FAIL rel_wrap got=%h exp=FFF", programCounter); end
        branch_abs = 1'b1; target = 12'h020; offset = 8'sh05;
        step();
        checks++; if (programCounter !== 12'h020) begin errors++; $display("FAIL abs_over_rel got=%h exp=020", programCounter); end
        branch_abs = 1'b0; offset = 8'sh10;
        step();
        checks++; if (programCounter !== 12'h030) begin errors++; $display("FAIL rel_fwd got=%h exp=030", programCounter); end
        clear_ctl();
    endtask

    task automatic test_halt();
        branch_abs = 1'b1; taken = 1'b1; target = 12'h007;
        step();
        halt = 1'b1; target = 12'h300;
        step();
        checks++; if (done !== 1'b1 || fetch_valid !== 1'b0) begin errors++; $display("FAIL halt_flags done=%b fv=%b exp done=1 fv=0", done, fetch_valid); end
        checks++; if (programCounter !== 12'h007) begin errors++; $display("FAIL halt_pc got=%h exp=007", programCounter); end
        halt = 1'b0;
        step();
        checks++; if (programCounter !== 12'h007 || done !== 1'b1) begin errors++; $display("FAIL done_hold pc=%h done=%b exp pc=007 done=1", programCounter, done); end
        clear_ctl(); start = 1'b1;
        step();
        checks++; if (programCounter !== 12'h000 || done !== 1'b0 || fetch_valid !== 1'b0) begin errors++; $display("FAIL restart_load pc=%h done=%b fv=%b exp pc=000 done=0 fv=0", programCounter, done, fetch_valid); end
        branch_abs = 1'b1; taken = 1'b1; target = 12'h0AA;
        step();
        checks++; if (programCounter !== 12'h000) begin errors++; $display("FAIL load_ignores_ctl got=%h exp=000", programCounter); end
        clear_ctl(); start = 1'b0;
        step();
        checks++; if (programCounter !== 12'h000 || fetch_valid !== 1'b1) begin errors++; $display("FAIL restart_run pc=%h fv=%b exp pc=000 fv=1", programCounter, fetch_valid); end
    endtask

    task automatic test_start_in_run();
        step(); step();
        start = 1'b1; halt = 1'b1; branch_abs = 1'b1; taken = 1'b1; target = 12'h123;
        step();
        checks++; if (programCounter !== 12'h000 || fetch_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL start_priority pc=%h fv=%b done=%b exp pc=000 fv=0 done=0", programCounter, fetch_valid, done); end
        clear_ctl(); start = 1'b0;
        step();
    endtask

    task automatic test_reset_midrun();
        branch_abs = 1'b1; taken = 1'b1; target = 12'h040;
        step();
        clear_ctl();
        checks++; if (programCounter !== 12'h040) begin errors++; $display("FAIL pre_reset_pc got=%h exp=040", programCounter); end
        reset = 1'b1; start = 1'b1;
        step();
        checks++; if (programCounter !== 12'h000 || fetch_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrun_reset pc=%h fv=%b done=%b exp pc=000 fv=0 done=0", programCounter, fetch_valid, done); end
        reset = 1'b0; start = 1'b0; branch_abs = 1'b1; taken = 1'b1; target = 12'h055; halt = 1'b1;
        step(); step(); step();
        checks++; if (programCounter !== 12'h000 || fetch_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_ignores_ctl pc=%h fv=%b done=%b exp pc=000 fv=0 done=0", programCounter, fetch_valid, done); end
        clear_ctl();
    endtask

`ifdef FETCH_CYCLE_COUNT_EN
    task automatic test_cycle_count();
        reset = 1'b1; clear_ctl(); start = 1'b0;
        step();
        reset = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL cc_start got=%0d exp=0", cycle_count); end
        repeat (9) step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        checks++; if (cycle_count !== 16'd10 || done !== 1'b1) begin errors++; $display("FAIL cc_ten cc=%0d done=%b exp cc=10 done=1", cycle_count, done); end
        step(); step();
        checks++; if (cycle_count !== 16'd10) begin errors++; $display("FAIL cc_hold_done got=%0d exp=10", cycle_count); end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        repeat (65540) @(posedge clk);
        #1;
        checks++; if (cycle_count !== 16'hFFFF) begin errors++; $display("FAIL cc_saturate got=%h exp=FFFF", cycle_count); end
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; clear_ctl();
        test_reset();
        test_sequential();
        test_branches();
        test_wrap();
        test_halt();
        test_start_in_run();
        test_reset_midrun();
`ifdef FETCH_CYCLE_COUNT_EN
        test_cycle_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
